// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and constants for the 2x2 matmul datapath
package matmul_pkg;
  localparam int DEF_ELEM_W = 4;
  localparam int DEF_N_ELEM = 4;
  localparam int ERR_FRAME = 0;
  localparam int ERR_TIMEOUT = 1;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} ld_state_e;
  typedef enum logic [1:0] {MM_IDLE, MM_MUL, MM_ACC, MM_DONE} mm_state_e;
endpackage

// File: rtl/matmul_operand_loader_bank.sv
// mm_operand_bank: one ping-pong bank holding a full A/B frame
module mm_operand_bank
  import matmul_pkg::*;
#(
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int N_ELEM = DEF_N_ELEM,
  localparam int IW = $clog2(2 * N_ELEM),
  localparam int MW = ELEM_W * N_ELEM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [IW-1:0]     idx_i,
  input  logic [ELEM_W-1:0] data_i,
  input  logic              set_full_i,
  input  logic              clr_full_i,
  output logic              full_o,
  output logic [MW-1:0]     a_o,
  output logic [MW-1:0]     b_o
);
  logic [2*MW-1:0] mem_q;
  logic            full_q;
  // B elements follow A in the stream, so one flat store splits cleanly into A|B
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (we_i) mem_q[int'(idx_i)*ELEM_W +: ELEM_W] <= data_i;
      if (set_full_i) full_q <= 1'b1;
      else if (clr_full_i) full_q <= 1'b0;
    end
  end
  assign full_o = full_q;
  assign a_o    = mem_q[MW-1:0];
  assign b_o    = mem_q[2*MW-1:MW];
endmodule

// File: rtl/matmul_operand_loader.sv
// matmul_operand_loader: packs a serial element stream into ping-pong A/B frames and issues them
module matmul_operand_loader
  import matmul_pkg::*;
#(
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int N_ELEM = DEF_N_ELEM,
  parameter int TIMEOUT = 64,
  localparam int MW = ELEM_W * N_ELEM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ELEM_W-1:0] s_data,
  input  logic              s_last,
  output logic [MW-1:0]     A,
  output logic [MW-1:0]     B,
  output logic              start,
  input  logic              mm_done,
  output logic              busy,
  output logic [1:0]        err,
  output logic [7:0]        frames_issued
);
  localparam int CW = $clog2(2 * N_ELEM);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(2 * N_ELEM - 1);
  localparam logic [TW-1:0] TMR_END = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  ld_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic        wr_q, wr_d, rd_q, rd_d;
  logic [MW-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  fi_q, fi_d;
  logic [1:0]  full;
  logic [MW-1:0] bank_a [2];
  logic [MW-1:0] bank_b [2];
  logic        xfer, at_end, frame_ok, frame_bad, timed_out, release_b;
  assign xfer      = s_valid && s_ready;
  assign at_end    = cnt_q == LAST_IDX;
  assign frame_ok  = xfer && at_end && s_last;
  assign frame_bad = xfer && (at_end != s_last);
  // tmr counts from the ISSUE cycle, so it hits TIMEOUT-1 on the last BUSY cycle before the limit
  assign timed_out = (TIMEOUT != 0) && state_q == BUSY && !mm_done && tmr_q >= TMR_END;
  assign release_b = state_q == BUSY && (mm_done || timed_out);
  for (genvar i = 0; i < 2; i++) begin : g_bank
    mm_operand_bank #(.ELEM_W(ELEM_W), .N_ELEM(N_ELEM)) u_bank (
      .clk       (clk),
      .reset     (reset),
      .we_i      (xfer && wr_q == 1'(i)),
      .idx_i     (cnt_q),
      .data_i    (s_data),
      .set_full_i(frame_ok && wr_q == 1'(i)),
      .clr_full_i(release_b && rd_q == 1'(i)),
      .full_o    (full[i]),
      .a_o       (bank_a[i]),
      .b_o       (bank_b[i])
    );
  end
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    fi_d = fi_q;
    cnt_d = xfer ? ((at_end || s_last) ? '0 : cnt_q + CW'(1)) : cnt_q;
    wr_d = wr_q ^ frame_ok;
    rd_d = rd_q ^ release_b;
    tmr_d = state_q == IDLE ? '0 : tmr_q + TW'(1);
    err_d = err_q;
    err_d[ERR_FRAME] = err_q[ERR_FRAME] | frame_bad;
    err_d[ERR_TIMEOUT] = err_q[ERR_TIMEOUT] | timed_out;
    case (state_q)
      IDLE: if (full[rd_q]) begin
        state_d = ISSUE;
        a_d = bank_a[rd_q];
        b_d = bank_b[rd_q];
      end
      ISSUE: begin
        state_d = BUSY;
        fi_d = fi_q + 8'd1;
      end
      BUSY: state_d = release_b ? IDLE : BUSY;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tmr_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      err_q <= '0;
      fi_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      a_q <= a_d;
      b_q <= b_d;
      err_q <= err_d;
      fi_q <= fi_d;
    end
  end
  assign s_ready = !full[wr_q];
  assign start = state_q == ISSUE;
  assign busy = state_q != IDLE;
  assign A = a_q;
  assign B = b_q;
  assign err = err_q;
  assign frames_issued = fi_q;
endmodule

// File: tb/tb_matmul_operand_loader.sv
// tb_matmul_operand_loader: random frames checked against a frame-level scoreboard model
module tb_matmul_operand_loader;
  localparam int TIMEOUT = 64;
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int t;
  } frame_t;
  logic clk = 0, reset = 1, s_valid = 0, s_last = 0, mm_done;
  logic [3:0] s_data = 0;
  logic s_ready, start, busy;
  logic [15:0] A, B;
  logic [1:0] err;
  logic [7:0] frames_issued;
  int n_checks = 0, n_fail = 0, cyc = 0;
  int done_dly = 6, wait_c, kick_req = 0, kick_ack = 0;
  bit spur = 0;
  frame_t pend[$];
  frame_t cur, fr;
  int occ, k, last_rel, s_cyc, mon_due;
  bit inflight, rel;
  logic [1:0] exp_err;
  logic [7:0] exp_fi;
  logic [3:0] elem [8];
  logic [3:0] fd [8];

  matmul_operand_loader #(.ELEM_W(4), .N_ELEM(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .A(A), .B(B), .start(start), .mm_done(mm_done), .busy(busy),
    .err(err), .frames_issued(frames_issued)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    pend.delete();
    occ = 0; k = 0; inflight = 0; exp_err = 0; exp_fi = 0; last_rel = -10;
  endtask

  // multiplier stand-in: done after done_dly cycles, on request, or spuriously while idle
  initial begin
    mm_done = 0;
    wait_c = 0;
    forever begin
      @(posedge clk);
      #2;
      mm_done = 0;
      if (reset) wait_c = 0;
      else if (kick_req != kick_ack) begin mm_done = 1; kick_ack = kick_req; end
      else if (start) wait_c = done_dly;
      else if (wait_c > 0) begin wait_c--; if (wait_c == 0) mm_done = 1; end
      else if (spur && !busy && $urandom_range(3) == 0) mm_done = 1;
    end
  end

  // scoreboard: frames queue on clean completion, issue at max(accept, release)+2
  always @(negedge clk) begin
    if (!reset) begin
      check("s_ready", s_ready, 32'(occ < 2));
      check("err", err, exp_err);
      check("frames_issued", frames_issued, exp_fi);
      mon_due = pend.size() > 0 ? ((pend[0].t > last_rel ? pend[0].t : last_rel) + 2) : -1;
      check("start", start, 32'(!inflight && cyc == mon_due));
      if (start) begin
        if (pend.size() > 0 && !inflight) cur = pend.pop_front();
        inflight = 1;
        s_cyc = cyc;
        exp_fi = exp_fi + 8'd1;
      end
      check("busy", busy, 32'(inflight));
      if (inflight) begin
        check("A", A, cur.a);
        check("B", B, cur.b);
      end
      rel = 0;
      if (inflight && cyc > s_cyc) begin
        if (mm_done) rel = 1;
        else if (TIMEOUT != 0 && cyc == s_cyc + TIMEOUT - 1) begin rel = 1; exp_err[1] = 1; end
      end
      if (rel) begin inflight = 0; occ--; last_rel = cyc; end
      if (s_valid && s_ready) begin
        elem[k] = s_data;
        if (s_last != (k == 7)) begin
          exp_err[0] = 1;
          k = 0;
        end else if (k == 7) begin
          fr.a = 0; fr.b = 0; fr.t = cyc;
          for (int j = 0; j < 4; j++) begin
            fr.a = fr.a + (16'(elem[j]) << (4 * j));
            fr.b = fr.b + (16'(elem[j+4]) << (4 * j));
          end
          pend.push_back(fr);
          occ++;
          k = 0;
        end else k++;
      end
    end
  end

  task automatic push(input logic [3:0] d, input logic last);
    int n = 0;
    s_valid = 1; s_data = d; s_last = last;
    while (!s_ready && n < 300) begin tick(); n++; end
    check("ready_wait", s_ready, 1);
    tick();
    s_valid = 0; s_last = 0;
    if ($urandom_range(3) == 0) tick();
  endtask

  task automatic send(input int n_el, input int last_at);
    for (int i = 0; i < n_el; i++) push(fd[i], i == last_at);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 8; i++) fd[i] = 4'($urandom_range(15));
  endtask

  task automatic seq_frame(input bit down);
    for (int i = 0; i < 8; i++) fd[i] = down ? 4'(8 - i) : 4'(i + 1);
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    while ((busy || occ != 0 || inflight) && n < lim) begin tick(); n++; end
    check("idle_wait", busy, 0);
  endtask

  task automatic wait_start(input int lim);
    int n = 0;
    while (!start && n < lim) begin tick(); n++; end
    check("start_wait", start, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) tick();
    check("rst_A", A, 0);
    check("rst_B", B, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_fi", frames_issued, 0);
    reset = 0;
    tick();
    check("rst_ready", s_ready, 1);
    // single frame 1..8
    done_dly = 6;
    seq_frame(0);
    send(8, 7);
    wait_idle(100);
    check("t1_A", A, 16'h4321);
    check("t1_B", B, 16'h8765);
    check("t1_fi", frames_issued, 1);
    // back-to-back with done withheld
    done_dly = -1;
    seq_frame(0);
    send(8, 7);
    seq_frame(1);
    send(8, 7);
    check("t2_full_ready", s_ready, 0);
    check("t2_hold_A", A, 16'h4321);
    kick_req++;
    tick();
    wait_start(10);
    check("t2_A", A, 16'h5678);
    check("t2_B", B, 16'h1234);
    repeat (5) tick();
    kick_req++;
    wait_idle(100);
    // framing error on 5th element
    done_dly = 4;
    rand_frame();
    send(5, 4);
    repeat (3) tick();
    check("t3_err", err, 2'b01);
    rand_frame();
    send(8, 7);
    wait_idle(100);
    check("t3_err_keep", err, 2'b01);
    // watchdog with a queued frame behind
    done_dly = -1;
    rand_frame();
    send(8, 7);
    rand_frame();
    send(8, 7);
    wait_idle(400);
    check("t4_err", err, 2'b11);
    // async reset while BUSY with both banks full
    rand_frame();
    send(8, 7);
    rand_frame();
    send(8, 7);
    @(posedge clk);
    #3;
    reset = 1;
    #1;
    check("t5_start", start, 0);
    check("t5_A", A, 0);
    check("t5_B", B, 0);
    check("t5_err", err, 0);
    check("t5_busy", busy, 0);
    check("t5_fi", frames_issued, 0);
    model_reset();
    repeat (2) tick();
    reset = 0;
    tick();
    check("t5_ready", s_ready, 1);
    done_dly = 6;
    seq_frame(0);
    send(8, 7);
    wait_idle(100);
    check("t5_A_new", A, 16'h4321);
    check("t5_fi_new", frames_issued, 1);
    // 255 more frames with immediate done and stray done pulses while idle
    done_dly = 1;
    spur = 1;
    for (int f = 0; f < 255; f++) begin
      rand_frame();
      send(8, 7);
    end
    wait_idle(100);
    spur = 0;
    check("t6_fi_wrap", frames_issued, 0);
    check("t6_err", err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
